// File: rtl/cfg_discovery_pkg.sv
// rtl/cfg_discovery_pkg.sv - word map, flag positions and table builder for the config discovery responder
package cfg_discovery_pkg;

    localparam int unsigned NUM_CFG_WORDS = 16;

    localparam int unsigned CFG_MAGIC_IDX    = 0;
    localparam int unsigned CFG_XLEN_IDX     = 1;
    localparam int unsigned CFG_ISA_IDX      = 2;
    localparam int unsigned CFG_IC_SIZE_IDX  = 3;
    localparam int unsigned CFG_IC_GEOM_IDX  = 4;
    localparam int unsigned CFG_DC_SIZE_IDX  = 5;
    localparam int unsigned CFG_DC_GEOM_IDX  = 6;
    localparam int unsigned CFG_DC_TYPE_IDX  = 7;
    localparam int unsigned CFG_PIPE_IDX     = 8;
    localparam int unsigned CFG_BPRED_IDX    = 9;
    localparam int unsigned CFG_MMU_IDX      = 10;
    localparam int unsigned CFG_AXI_IDX      = 11;
    localparam int unsigned CFG_FLAGS_IDX    = 12;
    localparam int unsigned CFG_HALT_IDX     = 13;
    localparam int unsigned CFG_EXC_IDX      = 14;
    localparam int unsigned CFG_CSUM_IDX     = 15;

    localparam logic [31:0] CFG_MAGIC = 32'h4356_4136;

    localparam int unsigned FLAG_MMU_PRESENT  = 0;
    localparam int unsigned FLAG_DEBUG_EN     = 1;
    localparam int unsigned FLAG_PERF_CNT_EN  = 2;
    localparam int unsigned FLAG_FPGA_EN      = 3;
    localparam int unsigned FLAG_TVAL_EN      = 4;
    localparam int unsigned FLAG_ZICOND       = 5;
    localparam int unsigned FLAG_CVXIF_EN     = 6;
    localparam int unsigned FLAG_SHARED_TLB   = 7;
    localparam int unsigned FLAG_SUPERSCALAR  = 8;

    typedef logic [NUM_CFG_WORDS-1:0][31:0] cfg_table_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_entry_t;

    function automatic cfg_table_t build_cfg_table(input config_pkg::cva6_cfg_t cfg);
        cfg_table_t  t;
        logic [31:0] csum;
        t = '0;
        t[CFG_MAGIC_IDX]   = CFG_MAGIC;
        t[CFG_XLEN_IDX]    = cfg.XLEN;
        // misa letter positions: bit n is letter ('A' + n)
        t[CFG_ISA_IDX][0]  = cfg.RVA;
        t[CFG_ISA_IDX][1]  = cfg.RVB;
        t[CFG_ISA_IDX][2]  = cfg.RVC;
        t[CFG_ISA_IDX][3]  = cfg.RVD;
        t[CFG_ISA_IDX][5]  = cfg.RVF;
        t[CFG_ISA_IDX][7]  = cfg.RVH;
        t[CFG_ISA_IDX][18] = cfg.RVS;
        t[CFG_ISA_IDX][20] = cfg.RVU;
        t[CFG_ISA_IDX][21] = cfg.RVV;
        t[CFG_IC_SIZE_IDX] = cfg.IcacheByteSize;
        t[CFG_IC_GEOM_IDX] = {cfg.IcacheLineWidth[15:0], cfg.IcacheSetAssoc[15:0]};
        t[CFG_DC_SIZE_IDX] = cfg.DcacheByteSize;
        t[CFG_DC_GEOM_IDX] = {cfg.DcacheLineWidth[15:0], cfg.DcacheSetAssoc[15:0]};
        t[CFG_DC_TYPE_IDX] = cfg.DCacheType;
        t[CFG_PIPE_IDX]    = {cfg.MaxOutstandingStores[7:0], cfg.NrLoadBufEntries[7:0],
                              cfg.NrCommitPorts[7:0], cfg.NrScoreboardEntries[7:0]};
        t[CFG_BPRED_IDX]   = {cfg.BHTEntries[11:0], cfg.BTBEntries[11:0], cfg.RASDepth[7:0]};
        t[CFG_MMU_IDX]     = {cfg.SharedTlbDepth[7:0], cfg.DataTlbEntries[7:0],
                              cfg.InstrTlbEntries[7:0], cfg.NrPMPEntries[7:0]};
        t[CFG_AXI_IDX]     = {cfg.MemTidWidth[7:0], cfg.AxiIdWidth[7:0],
                              cfg.AxiDataWidth[7:0], cfg.AxiAddrWidth[7:0]};
        t[CFG_FLAGS_IDX][FLAG_MMU_PRESENT] = cfg.MmuPresent;
        t[CFG_FLAGS_IDX][FLAG_DEBUG_EN]    = cfg.DebugEn;
        t[CFG_FLAGS_IDX][FLAG_PERF_CNT_EN] = cfg.PerfCounterEn;
        t[CFG_FLAGS_IDX][FLAG_FPGA_EN]     = cfg.FpgaEn;
        t[CFG_FLAGS_IDX][FLAG_TVAL_EN]     = cfg.TvalEn;
        t[CFG_FLAGS_IDX][FLAG_ZICOND]      = cfg.RVZiCond;
        t[CFG_FLAGS_IDX][FLAG_CVXIF_EN]    = cfg.CvxifEn;
        t[CFG_FLAGS_IDX][FLAG_SHARED_TLB]  = cfg.UseSharedTlb;
        t[CFG_FLAGS_IDX][FLAG_SUPERSCALAR] = cfg.SuperscalarEn;
        t[CFG_HALT_IDX]    = cfg.HaltAddress[31:0];
        t[CFG_EXC_IDX]     = cfg.ExceptionAddress[31:0];
        csum = '0;
        for (int i = 0; i < int'(CFG_CSUM_IDX); i++) begin
            csum = csum ^ t[i];
        end
        t[CFG_CSUM_IDX]    = csum;
        return t;
    endfunction

    // True when any field carries bits that fall outside its slot in the table.
    function automatic logic cfg_truncates(input config_pkg::cva6_cfg_t cfg);
        return (|cfg.IcacheSetAssoc[31:16])       || (|cfg.IcacheLineWidth[31:16])
            || (|cfg.DcacheSetAssoc[31:16])       || (|cfg.DcacheLineWidth[31:16])
            || (|cfg.NrScoreboardEntries[31:8])   || (|cfg.NrCommitPorts[31:8])
            || (|cfg.NrLoadBufEntries[31:8])      || (|cfg.MaxOutstandingStores[31:8])
            || (|cfg.RASDepth[31:8])              || (|cfg.BTBEntries[31:12])
            || (|cfg.BHTEntries[31:12])           || (|cfg.NrPMPEntries[31:8])
            || (|cfg.InstrTlbEntries[31:8])       || (|cfg.DataTlbEntries[31:8])
            || (|cfg.SharedTlbDepth[31:8])        || (|cfg.AxiAddrWidth[31:8])
            || (|cfg.AxiDataWidth[31:8])          || (|cfg.AxiIdWidth[31:8])
            || (|cfg.MemTidWidth[31:8])           || (|cfg.HaltAddress[63:32])
            || (|cfg.ExceptionAddress[63:32]);
    endfunction

endpackage

// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - elaborated CVA6 user configuration type and reference configurations
package config_pkg;

    typedef struct packed {
        logic [31:0] XLEN;
        logic        RVA;
        logic        RVB;
        logic        RVC;
        logic        RVD;
        logic        RVF;
        logic        RVH;
        logic        RVS;
        logic        RVU;
        logic        RVV;
        logic [31:0] IcacheByteSize;
        logic [31:0] IcacheSetAssoc;
        logic [31:0] IcacheLineWidth;
        logic [31:0] DcacheByteSize;
        logic [31:0] DcacheSetAssoc;
        logic [31:0] DcacheLineWidth;
        logic [31:0] DCacheType;
        logic [31:0] NrScoreboardEntries;
        logic [31:0] NrCommitPorts;
        logic [31:0] NrLoadBufEntries;
        logic [31:0] MaxOutstandingStores;
        logic [31:0] RASDepth;
        logic [31:0] BTBEntries;
        logic [31:0] BHTEntries;
        logic [31:0] NrPMPEntries;
        logic [31:0] InstrTlbEntries;
        logic [31:0] DataTlbEntries;
        logic [31:0] SharedTlbDepth;
        logic [31:0] AxiAddrWidth;
        logic [31:0] AxiDataWidth;
        logic [31:0] AxiIdWidth;
        logic [31:0] MemTidWidth;
        logic        MmuPresent;
        logic        DebugEn;
        logic        PerfCounterEn;
        logic        FpgaEn;
        logic        TvalEn;
        logic        RVZiCond;
        logic        CvxifEn;
        logic        UseSharedTlb;
        logic        SuperscalarEn;
        logic [63:0] HaltAddress;
        logic [63:0] ExceptionAddress;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

    localparam cva6_cfg_t cv32a6_imac_sv32 = '{
        XLEN:                 32'd32,
        RVA:                  1'b1,
        RVB:                  1'b0,
        RVC:                  1'b1,
        RVD:                  1'b0,
        RVF:                  1'b0,
        RVH:                  1'b0,
        RVS:                  1'b1,
        RVU:                  1'b1,
        RVV:                  1'b0,
        IcacheByteSize:       32'd16384,
        IcacheSetAssoc:       32'd4,
        IcacheLineWidth:      32'd128,
        DcacheByteSize:       32'd32768,
        DcacheSetAssoc:       32'd8,
        DcacheLineWidth:      32'd128,
        DCacheType:           32'd0,
        NrScoreboardEntries:  32'd8,
        NrCommitPorts:        32'd2,
        NrLoadBufEntries:     32'd2,
        MaxOutstandingStores: 32'd7,
        RASDepth:             32'd2,
        BTBEntries:           32'd32,
        BHTEntries:           32'd128,
        NrPMPEntries:         32'd8,
        InstrTlbEntries:      32'd2,
        DataTlbEntries:       32'd2,
        SharedTlbDepth:       32'd64,
        AxiAddrWidth:         32'd64,
        AxiDataWidth:         32'd64,
        AxiIdWidth:           32'd4,
        MemTidWidth:          32'd2,
        MmuPresent:           1'b1,
        DebugEn:              1'b1,
        PerfCounterEn:        1'b1,
        FpgaEn:               1'b0,
        TvalEn:               1'b1,
        RVZiCond:             1'b1,
        CvxifEn:              1'b1,
        UseSharedTlb:         1'b0,
        SuperscalarEn:        1'b0,
        HaltAddress:          64'h800,
        ExceptionAddress:     64'h808
    };

endpackage

// File: rtl/cfg_resp_fifo.sv
// rtl/cfg_resp_fifo.sv - 2-entry response FIFO with simultaneous push/pop and full-bypass grant
module cfg_resp_fifo
    import cfg_discovery_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    output logic        gnt,
    input  resp_entry_t push_entry,
    output logic        rvalid,
    output resp_entry_t head_entry,
    input  logic        rready
);

    logic [1:0]  count;
    resp_entry_t head;
    resp_entry_t tail;
    logic        push;
    logic        pop;

    assign rvalid     = (count != 2'd0);
    assign head_entry = head;
    // A full buffer still grants when the head leaves in the same cycle.
    assign gnt        = req && resetn && ((count != 2'd2) || rready);
    assign push       = gnt;
    assign pop        = rvalid && rready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_entry;
                    end else begin
                        head <= tail;
                        tail <= push_entry;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= push_entry;
                    end else begin
                        tail <= push_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    tail  <= '0;
                    count <= count - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/cfg_discovery_responder.sv
// rtl/cfg_discovery_responder.sv - read-only responder exposing the elaborated CVA6 configuration table
module cfg_discovery_responder
    import cfg_discovery_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
    parameter int unsigned           AddrWidth = 12,
    parameter int unsigned           NumWords  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 rerr_o,
    input  logic                 rready_i,
    output logic [7:0]           err_cnt_o
);

    localparam cfg_table_t      CfgTable = build_cfg_table(CVA6Cfg);
    localparam longint unsigned MaxWords = 64'd1 << (AddrWidth - 2);

    if (64'(NumWords) > MaxWords) begin : g_bad_numwords_hi
        $error("NumWords exceeds the address space");
    end
    if (NumWords < NUM_CFG_WORDS) begin : g_bad_numwords_lo
        $error("NumWords must cover the whole configuration table");
    end
    if (cfg_truncates(CVA6Cfg)) begin : g_cfg_truncated
        $error("configuration field wider than its table slot");
    end

    logic [AddrWidth-3:0] word_idx;
    logic                 addr_err;
    logic [31:0]          rd_word;
    resp_entry_t          push_entry;
    resp_entry_t          head_entry;
    logic                 push;
    logic [7:0]           err_cnt;

    assign word_idx = addr_i[AddrWidth-1:2];
    assign addr_err = we_i || (addr_i[1:0] != 2'b00) || (32'(word_idx) >= NumWords);
    // Mapped words beyond the table read as zero without flagging an error.
    assign rd_word  = (32'(word_idx) < NUM_CFG_WORDS) ? CfgTable[word_idx[3:0]] : 32'd0;

    assign push_entry.err  = addr_err;
    assign push_entry.data = addr_err ? 32'd0 : rd_word;

    cfg_resp_fifo u_resp_fifo (
        .clk        (clk_i),
        .resetn     (rst_ni),
        .req        (req_i),
        .gnt        (gnt_o),
        .push_entry (push_entry),
        .rvalid     (rvalid_o),
        .head_entry (head_entry),
        .rready     (rready_i)
    );

    assign rdata_o = head_entry.data;
    assign rerr_o  = head_entry.err;
    assign push    = req_i && gnt_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_cnt <= 8'd0;
        end else if (push && addr_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt;

endmodule
